exec_sequencer: RTL
===================

// Module: exec_sequencer
// PURPOSE
//  Multi-cycle sequencer between the instruction block and the controller/register/data-memory path.
//  Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB. Drives the single PC-increment strobe.
//  Gates the decoder's register and memory write enables so each fires exactly once per instruction.
//  Adds run/single-step/halt control, a data-memory ready handshake with timeout, and a retired-instruction counter.
// PARAMETERS
//  CNT_W    32  width of retired-instruction counter
//  MEM_TO   16  max cycles waiting for mem_ready in MEM before fault (>=1)
//  TO_W     $clog2(MEM_TO+1)  timeout counter width (derived, not overridden)
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rst         in   1      asynchronous, active-low reset (rst==0 resets immediately)
//  run_en      in   1      level: free-run instructions while high
//  step_req    in   1      pulse: execute exactly one instruction (accepted in IDLE only)
//  resume      in   1      pulse: leave HALT/FAULT back to IDLE
//  dec_we1     in   1      decoder register-file write enable (WE1)
//  dec_we2     in   1      decoder data-memory write enable (WE2)
//  dec_ld      in   1      decoder load select (MUXsel2), instruction reads data memory
//  dec_halt    in   1      decoder flags halt opcode
//  mem_ready   in   1      data memory completes access this cycle
//  pc_inc      out  1      one-cycle increment strobe to instruction block
//  we1_out     out  1      gated register write enable
//  we2_out     out  1      gated data-memory write enable
//  mem_req     out  1      data-memory access request (held through MEM)
//  busy        out  1      high in any state except IDLE/HALT/FAULT
//  halted      out  1      high in HALT or FAULT
//  fault       out  1      high in FAULT (memory timeout)
//  step_ack    out  1      one-cycle pulse when a single-step instruction retires
//  state_o     out  3      current state encoding (below)
//  icount      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset (rst==0, async):
//   - state=IDLE, icount=0, timeout counter=0, step-mode flag=0.
//   - All other outputs 0.
//  States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6 FAULT=7.
//   - All outputs are Moore, decoded from state; we1_out/we2_out additionally AND the dec_* inputs.
//  IDLE:
//   - step_req -> FETCH, step flag=1 (step_req wins if run_en also high).
//   - else run_en -> FETCH, step flag=0.
//   - else stay.
//  FETCH -> DECODE. DECODE: dec_halt -> HALT, else -> EXEC.
//  EXEC: (dec_we2|dec_ld) -> MEM, timeout cnt cleared; else -> WB.
//  MEM:
//   - mem_req=1 for the whole state.
//   - Cycle with mem_ready=1: we2_out=dec_we2, then -> WB.
//   - Else timeout cnt++; after MEM_TO consecutive not-ready cycles -> FAULT.
//   - Exactly MEM_TO wait cycles with mem_ready still low means fault.
//  WB:
//   - we1_out=dec_we1, pc_inc=1, icount+=1 (wraps modulo 2^CNT_W).
//   - step flag=1: step_ack=1, then -> IDLE.
//   - else run_en=1: -> FETCH; else -> IDLE.
//  HALT: pc_inc not asserted (PC stays on halt instr). resume -> IDLE; run_en/step_req ignored.
//  FAULT: fault=1. resume -> IDLE, clears fault. No writes issued.
//  Throughput: non-memory instr = 4 cycles (F,D,E,WB); memory instr = 5 + wait cycles.
//  run_en falling mid-instruction: current instruction completes to WB, then IDLE.
//  step_req/resume outside their accepting states: ignored, not queued.
//  Async reset mid-MEM: mem_req/we2_out drop immediately; no partial write counted.
//  we1_out, we2_out, pc_inc: at most one pulse each per instruction; never together except in WB (we2 never in WB).
// TESTING
//  T1 reset:
//   - rst=0 mid-EXEC -> all outputs 0 same cycle, icount=0, state_o=0.
//   - After rst=1 with run_en=0 -> stays IDLE.
//  T2 free-run ALU:
//   - run_en=1, dec_we1=1, dec_ld=dec_we2=0 for 3 instrs.
//   - pc_inc every 4th cycle, we1_out 3 pulses, icount=3.
//  T3 store:
//   - dec_we2=1, mem_ready low 2 cycles then high.
//   - mem_req high 3 cycles, we2_out one pulse on ready cycle, WB next, total 7 cycles.
//  T4 timeout:
//   - MEM_TO=16, dec_ld=1, mem_ready=0 forever -> FAULT after 16 MEM cycles, fault=1, pc_inc never pulses.
//   - resume -> IDLE, fault=0.
//  T5 single-step:
//   - step_req pulse with run_en=1 -> exactly one instruction, step_ack pulse at WB, back to IDLE.
//   - step_req during busy ignored.
//  T6 halt:
//   - dec_halt=1 at DECODE -> HALT, halted=1, no pc_inc/we pulses, icount unchanged.
//   - resume -> IDLE; icount 2^CNT_W-1 +1 wraps to 0 (force CNT_W=4).

Source files
------------

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle instruction sequencer.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, issues the single
// PC-increment strobe, lets each decoder write enable fire once per
// instruction, and adds run/step/halt control, a data-memory ready handshake
// with timeout, and a retired-instruction counter.
module exec_sequencer #(
  parameter int CNT_W  = 32,
  parameter int MEM_TO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic             step_req,
  input  logic             resume,
  input  logic             dec_we1,
  input  logic             dec_we2,
  input  logic             dec_ld,
  input  logic             dec_halt,
  input  logic             mem_ready,
  output logic             pc_inc,
  output logic             we1_out,
  output logic             we2_out,
  output logic             mem_req,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic             step_ack,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] icount
);

  localparam int TO_W = $clog2(MEM_TO + 1);
  // Value of the wait counter on the last not-ready MEM cycle before faulting.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  state_e            state_q;
  logic              step_q;
  logic [TO_W-1:0]   to_q;
  logic [CNT_W-1:0]  icount_q;

  // Sequencer state, step-mode flag, memory wait counter and retire counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      step_q   <= 1'b0;
      to_q     <= '0;
      icount_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (step_req) begin
            state_q <= S_FETCH;
            step_q  <= 1'b1;
          end else if (run_en) begin
            state_q <= S_FETCH;
            step_q  <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_FETCH: begin
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (dec_halt) begin
            state_q <= S_HALT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (dec_we2 || dec_ld) begin
            state_q <= S_MEM;
            to_q    <= '0;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            state_q <= S_WB;
          end else if (to_q == TO_LAST) begin
            // MEM_TO consecutive not-ready cycles: give up on this access.
            state_q <= S_FAULT;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end
        S_WB: begin
          icount_q <= icount_q + CNT_W'(1);
          if (step_q) begin
            state_q <= S_IDLE;
          end else if (run_en) begin
            state_q <= S_FETCH;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_HALT, S_FAULT: begin
          if (resume) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= state_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from the current state; write enables also qualify the decoder.
  always_comb begin
    pc_inc   = 1'b0;
    we1_out  = 1'b0;
    we2_out  = 1'b0;
    mem_req  = 1'b0;
    busy     = 1'b1;
    halted   = 1'b0;
    fault    = 1'b0;
    step_ack = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_MEM: begin
        mem_req = 1'b1;
        we2_out = mem_ready & dec_we2;
      end
      S_WB: begin
        pc_inc   = 1'b1;
        we1_out  = dec_we1;
        step_ack = step_q;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      S_FAULT: begin
        busy   = 1'b0;
        halted = 1'b1;
        fault  = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign state_o = state_q;
  assign icount  = icount_q;

endmodule
